// File: rtl/rx_fifo_if.sv
// rx_fifo_if: signal bundle between the UART receive side / host and rx_fifo.
//   master modport: drives RX_READY, DQ, FRAME_ERROR, RD_EN and OVF_CLR,
//                   and observes the FIFO status and head-entry outputs.
//   slave modport : the FIFO itself (rx_fifo).
//   Signals:
//     RX_READY    frame-complete flag from the receiver (may stay high)
//     DQ          received data word, valid while RX_READY is high
//     FRAME_ERROR stop-bit error tag of the current frame
//     RD_EN       pop head entry (ignored when EMPTY)
//     OVF_CLR     clear the sticky OVERFLOW flag
//     DOUT        head entry data (first-word-fall-through), 0 when EMPTY
//     DOUT_FE     head entry frame-error tag, 0 when EMPTY
//     EMPTY/FULL  occupancy flags derived from COUNT
//     COUNT       number of stored entries
//     OVERFLOW    sticky: a frame was dropped because the FIFO was full
//     FE_DROP_CNT saturating count of discarded errored frames
//                 (present only when RX_FIFO_DROP_FE_EN is defined)
interface rx_fifo_if #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             RX_READY;
   logic [WIDTH-1:0] DQ;
   logic             FRAME_ERROR;
   logic             RD_EN;
   logic             OVF_CLR;
   logic [WIDTH-1:0] DOUT;
   logic             DOUT_FE;
   logic             EMPTY;
   logic             FULL;
   logic [CW-1:0]    COUNT;
   logic             OVERFLOW;
`ifdef RX_FIFO_DROP_FE_EN
   logic [7:0]       FE_DROP_CNT;
`endif

   modport master (
      output RX_READY, DQ, FRAME_ERROR, RD_EN, OVF_CLR,
      input  DOUT, DOUT_FE, EMPTY, FULL, COUNT, OVERFLOW
`ifdef RX_FIFO_DROP_FE_EN
      , input FE_DROP_CNT
`endif
   );

   modport slave (
      input  RX_READY, DQ, FRAME_ERROR, RD_EN, OVF_CLR,
      output DOUT, DOUT_FE, EMPTY, FULL, COUNT, OVERFLOW
`ifdef RX_FIFO_DROP_FE_EN
      , output FE_DROP_CNT
`endif
   );
endinterface

// File: rtl/rx_fifo.sv
// rx_fifo: receive buffer placed directly after the UART receiver.
//   Captures {FRAME_ERROR, DQ} once per rising edge of RX_READY and queues
//   the entry in a first-word-fall-through FIFO popped by the host.
//   Ports:
//     CLK  system clock, rising edge
//     RST  synchronous reset, active high (discards all stored entries)
//     bus  rx_fifo_if.slave, see rx_fifo_if.sv for the signal list
//   Optional feature (macro RX_FIFO_DROP_FE_EN):
//     frames with FRAME_ERROR=1 are discarded instead of stored, counted
//     on FE_DROP_CNT (saturating at 255), and DOUT_FE is tied to 0.
module rx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input logic       CLK,
   input logic       RST,
   rx_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Storage: one entry = {frame_error, data}; intentionally not reset.
   logic [WIDTH:0]  r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_overflow;
   logic            r_rdy_q;

   logic            w_wr_evt;
   logic            w_store_req;
   logic            w_empty;
   logic            w_full;
   logic            w_rd_ok;
   logic            w_wr_ok;
   logic            w_drop;
   logic [WIDTH:0]  w_head;

   assign w_wr_evt = bus.RX_READY & ~r_rdy_q;

`ifdef RX_FIFO_DROP_FE_EN
   logic [7:0] r_fe_drop_cnt;
   // Errored frames never reach the queue, so they cannot overflow it.
   assign w_store_req = w_wr_evt & ~bus.FRAME_ERROR;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_fe_drop_cnt <= '0;
      end else if (w_wr_evt && bus.FRAME_ERROR && (r_fe_drop_cnt != 8'hFF)) begin
         r_fe_drop_cnt <= r_fe_drop_cnt + 8'd1;
      end
   end

   assign bus.FE_DROP_CNT = r_fe_drop_cnt;
`else
   assign w_store_req = w_wr_evt;
`endif

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_rd_ok = bus.RD_EN & ~w_empty;
   // When full, a coincident pop frees the head slot, which is exactly
   // the slot wr_ptr points at, so the write can proceed.
   assign w_wr_ok = w_store_req & (~w_full | w_rd_ok);
   assign w_drop  = w_store_req & w_full & ~w_rd_ok;

   // Edge detector; set during reset so a level already high at release
   // is not mistaken for a new frame.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rdy_q <= 1'b1;
      end else begin
         r_rdy_q <= bus.RX_READY;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
         always_ff @(posedge CLK) begin
            if (w_wr_ok && (r_wr_ptr == AW'(gi))) begin
               r_mem[gi] <= {bus.FRAME_ERROR, bus.DQ};
            end
         end
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A drop in the same cycle as OVF_CLR keeps the flag set.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (bus.OVF_CLR) begin
         r_overflow <= 1'b0;
      end
   end

   assign w_head = r_mem[r_rd_ptr];

   assign bus.DOUT     = w_empty ? '0 : w_head[WIDTH-1:0];
`ifdef RX_FIFO_DROP_FE_EN
   assign bus.DOUT_FE  = 1'b0;
`else
   assign bus.DOUT_FE  = w_empty ? 1'b0 : w_head[WIDTH];
`endif
   assign bus.EMPTY    = w_empty;
   assign bus.FULL     = w_full;
   assign bus.COUNT    = r_count;
   assign bus.OVERFLOW = r_overflow;
endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed plus randomized bench for rx_fifo, checked against a
// queue-based reference model of the receive buffer.
module tb_rx_fifo;
   localparam int DEPTH = 16;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // Reference model: queue of {fe, data}, head at index 0.
   logic [8:0] mq[$];
   logic       m_prev = 1'b1;
   logic       m_ovf  = 1'b0;
   int         m_fe_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [7:0] e_dout;
      logic       e_fe;
      e_dout = (mq.size() > 0) ? mq[0][7:0] : 8'h00;
      e_fe   = (mq.size() > 0) ? mq[0][8]   : 1'b0;
`ifdef RX_FIFO_DROP_FE_EN
      e_fe   = 1'b0;
      chk("fe_drop_cnt", 32'(bus.FE_DROP_CNT), 32'(m_fe_cnt));
`endif
      chk("count",    32'(bus.COUNT),    32'(mq.size()));
      chk("empty",    32'(bus.EMPTY),    32'(mq.size() == 0));
      chk("full",     32'(bus.FULL),     32'(mq.size() == DEPTH));
      chk("overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
      chk("dout",     32'(bus.DOUT),     32'(e_dout));
      chk("dout_fe",  32'(bus.DOUT_FE),  32'(e_fe));
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge.
   task automatic tick(input logic r, input logic rdy, input logic [7:0] dq,
                       input logic fe, input logic rd, input logic clr);
      logic evt, elig, rd_ok;
      rst             = r;
      bus.RX_READY    = rdy;
      bus.DQ          = dq;
      bus.FRAME_ERROR = fe;
      bus.RD_EN       = rd;
      bus.OVF_CLR     = clr;
      if (r) begin
         mq.delete();
         m_ovf    = 1'b0;
         m_prev   = 1'b1;
         m_fe_cnt = 0;
      end else begin
         evt    = rdy && !m_prev;
         m_prev = rdy;
         elig   = evt;
`ifdef RX_FIFO_DROP_FE_EN
         if (evt && fe) begin
            elig = 1'b0;
            if (m_fe_cnt < 255) m_fe_cnt++;
         end
`endif
         rd_ok = rd && (mq.size() > 0);
         if (elig && mq.size() == DEPTH && !rd_ok) begin
            m_ovf = 1'b1;
         end else begin
            if (clr) m_ovf = 1'b0;
         end
         if (rd_ok) void'(mq.pop_front());
         if (elig && mq.size() < DEPTH) mq.push_back({fe, dq});
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   // A complete frame: RX_READY high for 'hi' cycles, then low one cycle.
   task automatic frame(input logic [7:0] dq, input logic fe, input int hi);
      for (int k = 0; k < hi; k++) tick(1'b0, 1'b1, dq, fe, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] last_pop;
      int         hi;

      // Reset with RX_READY held high across release: no capture.
      tick(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      chk("hold_rdy_count", 32'(bus.COUNT), 32'd0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // 3-cycle RX_READY pulse gives exactly one entry, visible next cycle.
      tick(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      chk("t1_count", 32'(bus.COUNT), 32'd1);
      chk("t1_dout",  32'(bus.DOUT),  32'hA5);
      tick(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("t1_count_after", 32'(bus.COUNT), 32'd1);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Errored frame: stored with its tag, or discarded and counted.
      frame(8'h55, 1'b1, 2);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Fill with 0..15, then a 17th frame overflows.
      for (int i = 0; i < DEPTH; i++) frame(8'(i), 1'b0, 1);
      chk("fill_full", 32'(bus.FULL), 32'd1);
      frame(8'hFF, 1'b0, 1);
      chk("ovf_set", 32'(bus.OVERFLOW), 32'd1);
      chk("ovf_count", 32'(bus.COUNT), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         chk("pop_order", 32'(bus.DOUT), 32'(i));
         tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      chk("drained_empty", 32'(bus.EMPTY), 32'd1);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("ovf_clr", 32'(bus.OVERFLOW), 32'd0);

      // Full with a pop coincident with the write event.
      for (int i = 0; i < DEPTH; i++) frame(8'($urandom_range(0, 255)), 1'b0, 1);
      tick(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
      chk("fullrw_count", 32'(bus.COUNT), 32'd16);
      chk("fullrw_ovf", 32'(bus.OVERFLOW), 32'd0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      last_pop = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         last_pop = bus.DOUT;
         tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      chk("fullrw_last", 32'(last_pop), 32'h3C);

      // Write event and pop while empty: write wins, COUNT=1.
      tick(1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
      chk("empty_rw_count", 32'(bus.COUNT), 32'd1);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Drop coincident with OVF_CLR: set wins.
      for (int i = 0; i < DEPTH; i++) frame(8'(i + 32), 1'b0, 1);
      tick(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      chk("ovf_set_wins", 32'(bus.OVERFLOW), 32'd1);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Reset mid-operation discards contents.
      tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("midrst_count", 32'(bus.COUNT), 32'd0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Randomized interleaved traffic over 40 frames (pointers wrap).
      for (int f = 0; f < 40; f++) begin
         hi = int'($urandom_range(1, 3));
         for (int k = 0; k < hi; k++)
            tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0));
         for (int k = 0; k < int'($urandom_range(1, 2)); k++)
            tick(1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0,
                 ($urandom_range(0, 2) != 0), 1'b0);
      end
      for (int i = 0; i < DEPTH + 2; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("rd_empty_count", 32'(bus.COUNT), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
